// File: rtl/fetch_unit.sv
// Fetch unit: takes PCs from the pc stage, reads instruction memory one request at a time,
// and queues {pc, instr} pairs for decode. Define FETCH_STATS_EN to add fetch/stall counters.
module fetch_unit #(
  parameter int ADDR_W  = 32,
  parameter int INSTR_W = 32,
  parameter int DEPTH   = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pc_valid,
  input  logic [ADDR_W-1:0]  pc_addr,
  output logic               pc_ready,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               flush,
  output logic               id_valid,
  input  logic               id_ready,
  output logic [INSTR_W-1:0] id_instr,
  output logic [ADDR_W-1:0]  id_pc
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]        stat_fetched,
  output logic [31:0]        stat_stall
`endif
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DROP} state_t;

  state_t              r_state, w_next;
  logic [ADDR_W-1:0]   r_addr;
  logic [INSTR_W-1:0]  r_instr [DEPTH];
  logic [ADDR_W-1:0]   r_pcq   [DEPTH];
  logic [PW-1:0]       r_wptr, r_rptr;
  logic [CW-1:0]       r_count;
  logic                w_accept, w_push, w_pop;

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic; an ack always retires the outstanding request
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_accept) w_next = S_REQ;
      S_REQ:   if (imem_ack) w_next = S_IDLE;
               else if (flush) w_next = S_DROP;
      S_DROP:  if (imem_ack) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Output logic; accepting only with a free slot means a push can never overflow
  always_comb begin
    pc_ready = (r_state == S_IDLE) && !flush && !rst && (r_count < CW'(DEPTH));
    imem_req = (r_state != S_IDLE);
    w_push   = (r_state == S_REQ) && imem_ack && !flush;
  end

  assign w_accept  = pc_valid && pc_ready;
  assign w_pop     = id_valid && id_ready;
  assign imem_addr = r_addr;

  always_ff @(posedge clk) begin
    if (rst)           r_addr <= '0;
    else if (w_accept) r_addr <= pc_addr;
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_instr[r_wptr] <= imem_rdata;
      r_pcq[r_wptr]   <= r_addr;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two; flush wins over push/pop
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign id_valid = (r_count != '0);
  assign id_instr = id_valid ? r_instr[r_rptr] : '0;
  assign id_pc    = id_valid ? r_pcq[r_rptr]   : '0;

`ifdef FETCH_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_fetched <= '0;
      stat_stall   <= '0;
    end else begin
      if (w_push && (stat_fetched != '1))                   stat_fetched <= stat_fetched + 1'b1;
      if (imem_req && !imem_ack && (stat_stall != '1))      stat_stall   <= stat_stall + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus random traffic, every cycle compared
// against a queue-based reference of the fetch pipeline.
module tb_fetch_unit;
  localparam int AW = 32;
  localparam int IW = 32;
  localparam int D  = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1, pc_valid = 1'b0, imem_ack = 1'b0, flush = 1'b0, id_ready = 1'b0;
  logic [AW-1:0] pc_addr = '0;
  logic [IW-1:0] imem_rdata = '0;
  logic          pc_ready, imem_req, id_valid;
  logic [AW-1:0] imem_addr, id_pc;
  logic [IW-1:0] id_instr;
`ifdef FETCH_STATS_EN
  logic [31:0]   stat_fetched, stat_stall;
  logic [31:0]   m_fet = '0, m_stl = '0;
`endif

  always #5 clk = ~clk;

  fetch_unit #(.ADDR_W(AW), .INSTR_W(IW), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .pc_valid(pc_valid), .pc_addr(pc_addr), .pc_ready(pc_ready),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .flush(flush), .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr), .id_pc(id_pc)
`ifdef FETCH_STATS_EN
    , .stat_fetched(stat_fetched), .stat_stall(stat_stall)
`endif
  );

  int cnt = 0, fails = 0;

  // Reference: a queue of buffered {pc, instr} plus one outstanding request
  logic [AW-1:0] mq_pc [$];
  logic [IW-1:0] mq_in [$];
  bit            m_busy = 0, m_drop = 0;
  logic [AW-1:0] m_addr = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    cnt++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input bit r, input bit pv, input logic [31:0] a, input bit ak,
                       input logic [31:0] rd, input bit fl, input bit idr);
    rst = r; pc_valid = pv; pc_addr = a; imem_ack = ak; imem_rdata = rd; flush = fl; id_ready = idr;
    #1;
  endtask

  task automatic tick();
    bit e_rdy, e_idv, pop, push, acc;
    e_rdy = !rst && !m_busy && !flush && (mq_pc.size() < D);
    e_idv = mq_pc.size() > 0;
    chk("pc_ready",  pc_ready,  e_rdy);
    chk("imem_req",  imem_req,  m_busy);
    chk("imem_addr", imem_addr, m_addr);
    chk("id_valid",  id_valid,  e_idv);
    chk("id_pc",     id_pc,     e_idv ? mq_pc[0] : '0);
    chk("id_instr",  id_instr,  e_idv ? mq_in[0] : '0);
`ifdef FETCH_STATS_EN
    chk("stat_fetched", stat_fetched, m_fet);
    chk("stat_stall",   stat_stall,   m_stl);
`endif
    if (rst) begin
      mq_pc.delete(); mq_in.delete();
      m_busy = 0; m_drop = 0; m_addr = '0;
`ifdef FETCH_STATS_EN
      m_fet = '0; m_stl = '0;
`endif
    end else begin
      pop  = e_idv && id_ready;
      acc  = pc_valid && e_rdy;
      push = m_busy && !m_drop && imem_ack && !flush;
`ifdef FETCH_STATS_EN
      if (push && m_fet != '1) m_fet = m_fet + 1;
      if (m_busy && !imem_ack && m_stl != '1) m_stl = m_stl + 1;
`endif
      if (flush) begin
        mq_pc.delete(); mq_in.delete();
      end else begin
        if (pop) begin void'(mq_pc.pop_front()); void'(mq_in.pop_front()); end
        if (push) begin mq_pc.push_back(m_addr); mq_in.push_back(imem_rdata); end
      end
      if (m_busy && imem_ack) begin m_busy = 0; m_drop = 0; end
      else if (m_busy && flush) m_drop = 1;
      if (acc) begin m_busy = 1; m_addr = pc_addr; end
    end
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    // Reset held three cycles: everything quiet, pc_ready low in reset
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 32'h10, 0, 0, 0, 1);
      chk("rst_pc_ready", pc_ready, 0);
      chk("rst_id_valid", id_valid, 0);
      chk("rst_imem_req", imem_req, 0);
      chk("rst_imem_addr", imem_addr, 0);
      chk("rst_id_pc", id_pc, 0);
      tick();
    end
    // First cycle after reset accepts 0x10; zero-wait ack
    drive(0, 1, 32'h10, 0, 0, 0, 1);
    chk("post_rst_ready", pc_ready, 1);
    tick();
    drive(0, 0, 0, 1, 32'hDEAD_BEEF, 0, 1);
    chk("t2_req", imem_req, 1);
    chk("t2_addr", imem_addr, 32'h10);
    tick();
    drive(0, 0, 0, 0, 0, 0, 1);
    chk("t2_valid", id_valid, 1);
    chk("t2_pc", id_pc, 32'h10);
    chk("t2_instr", id_instr, 32'hDEAD_BEEF);
    tick();
    // Fill FIFO with 0x0 and 0x4, then drain in order
    drive(0, 1, 32'h0, 0, 0, 0, 0); tick();
    drive(0, 0, 0, 1, 32'hA000_0000, 0, 0); tick();
    drive(0, 1, 32'h4, 0, 0, 0, 0); tick();
    drive(0, 0, 0, 1, 32'hA000_0004, 0, 0); tick();
    drive(0, 1, 32'h8, 0, 0, 0, 0);
    chk("t3_full_ready", pc_ready, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 1);
    chk("t3_pop0_pc", id_pc, 32'h0);
    chk("t3_pop0_instr", id_instr, 32'hA000_0000);
    tick();
    drive(0, 0, 0, 0, 0, 0, 1);
    chk("t3_pop1_pc", id_pc, 32'h4);
    chk("t3_pop1_instr", id_instr, 32'hA000_0004);
    tick();
    drive(0, 0, 0, 0, 0, 0, 1);
    chk("t3_empty", id_valid, 0);
    tick();
    // Flush during REQ on 0x8, ack three cycles later is dropped
    drive(0, 1, 32'h8, 0, 0, 0, 1); tick();
    drive(0, 0, 0, 0, 0, 1, 1); tick();
    drive(0, 0, 0, 0, 0, 0, 1); tick();
    drive(0, 0, 0, 0, 0, 0, 1); tick();
    drive(0, 0, 0, 1, 32'h1234, 0, 1);
    chk("t4_req_held", imem_req, 1);
    tick();
    drive(0, 0, 0, 0, 0, 0, 1);
    chk("t4_ready", pc_ready, 1);
    chk("t4_valid", id_valid, 0);
    chk("t4_req_drop", imem_req, 0);
    tick();
    // Flush + ack together with one entry buffered
    drive(0, 1, 32'h20, 0, 0, 0, 0); tick();
    drive(0, 0, 0, 1, 32'h5555, 0, 0); tick();
    drive(0, 1, 32'h24, 0, 0, 0, 0); tick();
    drive(0, 0, 0, 1, 32'h6666, 1, 0);
    chk("t5_req", imem_req, 1);
    chk("t5_buffered", id_valid, 1);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("t5_valid", id_valid, 0);
    chk("t5_ready", pc_ready, 1);
    chk("t5_req", imem_req, 0);
    tick();
`ifdef FETCH_STATS_EN
    drive(1, 0, 0, 0, 0, 0, 1); tick();
    for (int f = 0; f < 3; f++) begin
      drive(0, 1, 32'h100 + 4 * f, 0, 0, 0, 1); tick();
      drive(0, 0, 0, 0, 0, 0, 1); tick();
      drive(0, 0, 0, 0, 0, 0, 1); tick();
      drive(0, 0, 0, 1, 32'hC0DE_0000 + f, 0, 1); tick();
    end
    drive(0, 0, 0, 0, 0, 0, 1);
    chk("t6_fetched", stat_fetched, 3);
    chk("t6_stall", stat_stall, 6);
    tick();
`endif
    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      drive($urandom_range(0, 99) == 0, ($urandom % 10) < 7, $urandom & 32'hFFFF_FFFC,
            ($urandom % 10) < 4, $urandom, ($urandom % 12) == 0, $urandom % 2);
      tick();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", cnt, fails);
    $finish;
  end
endmodule
